// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings shared by the universal shift register and its bench.
package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROTL = 3'd4,
        MODE_ROTR = 3'd5,
        MODE_ASR  = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    function automatic logic is_fill_shift(input logic [2:0] mode);
        return mode == MODE_SHL || mode == MODE_SHR;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: valid-bit counter with clear, set-to-max, saturating increment and fill pulse.
module sat_counter #(
    parameter int MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       set_i,
    input  logic                       inc_i,
    output logic [$clog2(MAX+1)-1:0]   cnt_o,
    output logic                       full_o,
    output logic                       done_o
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] TOP   = CW'(MAX);
    localparam logic [CW-1:0] TOPM1 = CW'(MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = clr_i ? '0 : set_i ? TOP : (inc_i && cnt_q != TOP) ? cnt_q + 1'b1 : cnt_q;
        done_d = !clr_i && inc_i && cnt_q == TOPM1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = cnt_q == TOP;
    assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register (load, shift, rotate, arithmetic shift) with fill tracking.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           D,
    input  logic                       sin_r,
    input  logic                       sin_l,
    output logic [WIDTH-1:0]           Q,
    output logic                       sout_l,
    output logic                       sout_r,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             load, shift;

    always_comb begin
        load  = en && mode == MODE_LOAD;
        shift = en && is_fill_shift(mode);
        q_d   = clr                ? '0 :
                !en                ? q_q :
                mode == MODE_LOAD  ? D :
                mode == MODE_SHL   ? {q_q[WIDTH-2:0], sin_r} :
                mode == MODE_SHR   ? {sin_l, q_q[WIDTH-1:1]} :
                mode == MODE_ROTL  ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
                mode == MODE_ROTR  ? {q_q[0], q_q[WIDTH-1:1]} :
                mode == MODE_ASR   ? {q_q[WIDTH-1], q_q[WIDTH-1:1]} :
                                     q_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= RESET_VAL;
        else        q_q <= q_d;
    end

    sat_counter #(.MAX(WIDTH)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .set_i  (load),
        .inc_i  (shift),
        .cnt_o  (cnt),
        .full_o (full),
        .done_o (done)
    );

    assign Q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];

endmodule
